// File: rtl/tta_fetch.sv
// Direct-mapped instruction cache front end for the TTA core: combinational lookup, line refill.
// Optional flush port enabled by defining TTA_FETCH_FLUSH_EN.
module tta_fetch #(
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned IWIDTH = 32,
    parameter int unsigned INDEX  = 6,
    parameter int unsigned LINE   = 2
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic [WIDTH-1:0]  pc_i,
    input  logic              fetch_i,
    output logic              ack_o,
    output logic              hit_o,
    output logic [IWIDTH-1:0] instr_o,
    output logic              mem_req_o,
    output logic [WIDTH-1:0]  mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [IWIDTH-1:0] mem_data_i
`ifdef TTA_FETCH_FLUSH_EN
    ,
    input  logic              flush_i
`endif
);

    localparam int unsigned TagW  = WIDTH - INDEX - LINE;
    localparam int unsigned Lines = 1 << INDEX;
    localparam int unsigned Words = 1 << (INDEX + LINE);

    typedef enum logic [0:0] {StLookup, StRefill} state_e;

    logic [LINE-1:0]   offset;
    logic [INDEX-1:0]  index;
    logic [TagW-1:0]   tag;

    // Storage is deliberately left unreset; the valid bits alone qualify it.
    logic [TagW-1:0]   tag_mem  [Lines];
    logic [IWIDTH-1:0] data_mem [Words];

    logic [Lines-1:0]  valid_q, valid_d;
    state_e            state_q, state_d;
    logic [TagW-1:0]   ref_tag_q, ref_tag_d;
    logic [INDEX-1:0]  ref_index_q, ref_index_d;
    logic [LINE-1:0]   count_q, count_d;

    logic              lookup_hit;
    logic              refill_word;
    logic              last_word;
    logic              flush_lookup;
    logic              flush_at_end;

    assign offset = pc_i[LINE-1:0];
    assign index  = pc_i[LINE+INDEX-1:LINE];
    assign tag    = pc_i[WIDTH-1:LINE+INDEX];

    assign lookup_hit  = (state_q == StLookup) && valid_q[index] && (tag_mem[index] == tag);
    assign refill_word = (state_q == StRefill) && mem_ack_i;
    assign last_word   = refill_word && (count_q == {LINE{1'b1}});

`ifdef TTA_FETCH_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    assign flush_lookup = flush_i && (state_q == StLookup);
    // A flush seen during refill is deferred so the outstanding line still completes.
    assign flush_at_end = flush_pend_q || flush_i;

    always_comb begin
        flush_pend_d = flush_pend_q;
        if (state_q == StRefill) begin
            if (last_word) begin
                flush_pend_d = 1'b0;
            end else if (flush_i) begin
                flush_pend_d = 1'b1;
            end
        end else begin
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign flush_lookup = 1'b0;
    assign flush_at_end = 1'b0;
`endif

    assign ack_o      = fetch_i && lookup_hit && !flush_lookup;
    assign hit_o      = last_word;
    assign instr_o    = data_mem[{index, offset}];
    assign mem_req_o  = (state_q == StRefill);
    assign mem_addr_o = {ref_tag_q, ref_index_q, {LINE{1'b0}}};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        ref_tag_d   = ref_tag_q;
        ref_index_d = ref_index_q;
        count_d     = count_q;
        unique case (state_q)
            StLookup: begin
                if (flush_lookup) begin
                    valid_d = '0;
                end else if (fetch_i && !lookup_hit) begin
                    ref_tag_d      = tag;
                    ref_index_d    = index;
                    count_d        = '0;
                    // Line stays invalid until its last word lands.
                    valid_d[index] = 1'b0;
                    state_d        = StRefill;
                end
            end
            StRefill: begin
                if (mem_ack_i) begin
                    count_d = count_q + LINE'(1);
                    if (last_word) begin
                        state_d = StLookup;
                        if (flush_at_end) begin
                            valid_d = '0;
                        end else begin
                            valid_d[ref_index_q] = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StLookup;
            valid_q     <= '0;
            ref_tag_q   <= '0;
            ref_index_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ref_tag_q   <= ref_tag_d;
            ref_index_q <= ref_index_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (refill_word) begin
            data_mem[{ref_index_q, count_q}] <= mem_data_i;
        end
        if (last_word) begin
            tag_mem[ref_index_q] <= ref_tag_q;
        end
    end

endmodule

// File: tb/tb_tta_fetch.sv
// Directed bench for tta_fetch (WIDTH=18, INDEX=6, LINE=2); flush scenario built with TTA_FETCH_FLUSH_EN.
module tb_tta_fetch;

    localparam int W  = 18;
    localparam int IW = 32;

    localparam logic [IW-1:0] ABase = 32'hA000_0000;
    localparam logic [IW-1:0] BBase = 32'hB000_0000;
    localparam logic [IW-1:0] CBase = 32'hC000_0000;
    localparam logic [IW-1:0] DBase = 32'hD000_0000;
    localparam logic [IW-1:0] EBase = 32'hE000_0000;

    logic          clock_i    = 1'b0;
    logic          reset_ni   = 1'b1;
    logic [W-1:0]  pc_i       = '0;
    logic          fetch_i    = 1'b0;
    logic          mem_ack_i  = 1'b0;
    logic [IW-1:0] mem_data_i = '0;
`ifdef TTA_FETCH_FLUSH_EN
    logic          flush_i    = 1'b0;
`endif
    logic          ack_o;
    logic          hit_o;
    logic [IW-1:0] instr_o;
    logic          mem_req_o;
    logic [W-1:0]  mem_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    tta_fetch #(
        .WIDTH (W),
        .IWIDTH(IW),
        .INDEX (6),
        .LINE  (2)
    ) dut (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .pc_i      (pc_i),
        .fetch_i   (fetch_i),
        .ack_o     (ack_o),
        .hit_o     (hit_o),
        .instr_o   (instr_o),
        .mem_req_o (mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i (mem_ack_i),
        .mem_data_i(mem_data_i)
`ifdef TTA_FETCH_FLUSH_EN
        ,
        .flush_i   (flush_i)
`endif
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #500000;
        $display("FAIL timeout: simulation ran past 500000 time units");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clock_i);
        #1;
    endtask

    // Serves one line refill after a miss cycle, gap idle cycles before each strobe.
    task automatic refill(input logic [IW-1:0] base, input int gap, input logic [W-1:0] addr);
        logic [W-1:0] pc_save;
        logic         fetch_save;
        logic         exp_hit;
        pc_save    = pc_i;
        fetch_save = fetch_i;
        next_cycle();
        #1;
        n_checks++;
        if (mem_req_o !== 1'b1) $display("FAIL refill_req: mem_req_o=%b expected 1", mem_req_o);
        else n_pass++;
        n_checks++;
        if (mem_addr_o !== addr) $display("FAIL refill_addr: mem_addr_o=%h expected %h", mem_addr_o, addr);
        else n_pass++;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL refill_ack: ack_o=%b expected 0", ack_o);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                next_cycle();
                mem_ack_i = 1'b0;
                pc_i      = ~pc_save;
                fetch_i   = ~fetch_save;
                #1;
                n_checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== addr)
                    $display("FAIL stall_req: mem_req_o=%b addr=%h expected 1/%h",
                             mem_req_o, mem_addr_o, addr);
                else n_pass++;
                n_checks++;
                if (ack_o !== 1'b0 || hit_o !== 1'b0)
                    $display("FAIL stall_idle: ack_o=%b hit_o=%b expected 0/0", ack_o, hit_o);
                else n_pass++;
            end
            next_cycle();
            pc_i       = pc_save;
            fetch_i    = fetch_save;
            mem_ack_i  = 1'b1;
            mem_data_i = base + IW'(i);
            #1;
            exp_hit = (i == 3);
            n_checks++;
            if (hit_o !== exp_hit)
                $display("FAIL refill_hit: word %0d hit_o=%b expected %b", i, hit_o, exp_hit);
            else n_pass++;
            n_checks++;
            if (ack_o !== 1'b0) $display("FAIL refill_word_ack: word %0d ack_o=%b expected 0", i, ack_o);
            else n_pass++;
        end
        next_cycle();
        mem_ack_i = 1'b0;
        #1;
        n_checks++;
        if (hit_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL refill_done: hit_o=%b mem_req_o=%b expected 0/0", hit_o, mem_req_o);
        else n_pass++;
    endtask

    task automatic test_reset();
        #2;
        reset_ni  = 1'b0;
        pc_i      = '0;
        fetch_i   = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || hit_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL reset_outputs: ack=%b hit=%b req=%b expected 0/0/0", ack_o, hit_o, mem_req_o);
        else n_pass++;
        next_cycle();
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || ack_o !== 1'b0)
            $display("FAIL reset_held: req=%b ack=%b expected 0/0", mem_req_o, ack_o);
        else n_pass++;
        mem_ack_i = 1'b0;
        fetch_i   = 1'b0;
        reset_ni  = 1'b1;
        next_cycle();
    endtask

    task automatic test_cold_miss();
        pc_i    = 18'h00104;
        fetch_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL cold_miss: ack=%b req=%b expected 0/0", ack_o, mem_req_o);
        else n_pass++;
        refill(ABase, 0, 18'h00104);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase)
            $display("FAIL cold_after: ack=%b instr=%h expected 1/%h", ack_o, instr_o, ABase);
        else n_pass++;
    endtask

    task automatic test_hit();
        next_cycle();
        pc_i = 18'h00106;
        #1;
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase + 32'd2 || mem_req_o !== 1'b0)
            $display("FAIL hit_106: ack=%b instr=%h req=%b expected 1/%h/0",
                     ack_o, instr_o, mem_req_o, ABase + 32'd2);
        else n_pass++;
        pc_i = 18'h00107;
        #1;
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase + 32'd3)
            $display("FAIL hit_107: ack=%b instr=%h expected 1/%h", ack_o, instr_o, ABase + 32'd3);
        else n_pass++;
    endtask

    task automatic test_ack_in_lookup();
        next_cycle();
        pc_i       = 18'h00104;
        fetch_i    = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || hit_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL stray_ack: ack=%b hit=%b req=%b expected 0/0/0", ack_o, hit_o, mem_req_o);
        else n_pass++;
        next_cycle();
        mem_ack_i = 1'b0;
        fetch_i   = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase)
            $display("FAIL stray_intact: ack=%b instr=%h expected 1/%h", ack_o, instr_o, ABase);
        else n_pass++;
    endtask

    task automatic test_conflict();
        next_cycle();
        pc_i = 18'h00204;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL conflict_miss: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(BBase, 0, 18'h00204);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== BBase)
            $display("FAIL conflict_fill: ack=%b instr=%h expected 1/%h", ack_o, instr_o, BBase);
        else n_pass++;
        next_cycle();
        pc_i = 18'h00104;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL conflict_evict: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(ABase, 0, 18'h00104);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase)
            $display("FAIL conflict_back: ack=%b instr=%h expected 1/%h", ack_o, instr_o, ABase);
        else n_pass++;
    endtask

    task automatic test_boundary();
        next_cycle();
        pc_i = 18'h3FFFF;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL top_miss: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(CBase, 0, 18'h3FFFC);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== CBase + 32'd3)
            $display("FAIL top_word3: ack=%b instr=%h expected 1/%h", ack_o, instr_o, CBase + 32'd3);
        else n_pass++;
        pc_i = 18'h3FFFC;
        #1;
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== CBase)
            $display("FAIL top_word0: ack=%b instr=%h expected 1/%h", ack_o, instr_o, CBase);
        else n_pass++;
    endtask

    task automatic test_stalled();
        next_cycle();
        pc_i = 18'h00308;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL stall_miss: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(DBase, 3, 18'h00308);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== DBase)
            $display("FAIL stall_word0: ack=%b instr=%h expected 1/%h", ack_o, instr_o, DBase);
        else n_pass++;
        pc_i = 18'h0030B;
        #1;
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== DBase + 32'd3)
            $display("FAIL stall_word3: ack=%b instr=%h expected 1/%h", ack_o, instr_o, DBase + 32'd3);
        else n_pass++;
    endtask

    task automatic test_reset_mid_refill();
        next_cycle();
        pc_i = 18'h00204;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL rmid_miss: ack=%b expected 0", ack_o);
        else n_pass++;
        next_cycle();
        mem_ack_i  = 1'b1;
        mem_data_i = EBase;
        next_cycle();
        mem_data_i = EBase + 32'd1;
        next_cycle();
        mem_ack_i = 1'b0;
        reset_ni  = 1'b0;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || hit_o !== 1'b0 || ack_o !== 1'b0)
            $display("FAIL rmid_abort: req=%b hit=%b ack=%b expected 0/0/0", mem_req_o, hit_o, ack_o);
        else n_pass++;
        next_cycle();
        reset_ni   = 1'b1;
        fetch_i    = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = EBase + 32'd2;
        #1;
        n_checks++;
        if (hit_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL rmid_stray: hit=%b req=%b expected 0/0", hit_o, mem_req_o);
        else n_pass++;
        next_cycle();
        mem_ack_i = 1'b0;
        pc_i      = 18'h00104;
        fetch_i   = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL rmid_remiss: ack=%b req=%b expected 0/0", ack_o, mem_req_o);
        else n_pass++;
        refill(ABase, 0, 18'h00104);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase)
            $display("FAIL rmid_refill: ack=%b instr=%h expected 1/%h", ack_o, instr_o, ABase);
        else n_pass++;
        pc_i = 18'h00308;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL rmid_other_invalid: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(DBase, 0, 18'h00308);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== DBase)
            $display("FAIL rmid_other_fill: ack=%b instr=%h expected 1/%h", ack_o, instr_o, DBase);
        else n_pass++;
    endtask

`ifdef TTA_FETCH_FLUSH_EN
    task automatic test_flush();
        next_cycle();
        pc_i = 18'h00104;
        #1;
        n_checks++;
        if (ack_o !== 1'b1) $display("FAIL flush_pre: ack=%b expected 1", ack_o);
        else n_pass++;
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL flush_same_cycle: ack=%b expected 0", ack_o);
        else n_pass++;
        next_cycle();
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL flush_miss: ack=%b expected 0", ack_o);
        else n_pass++;
        next_cycle();
        flush_i = 1'b1;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b1) $display("FAIL flush_refill_req: req=%b expected 1", mem_req_o);
        else n_pass++;
        next_cycle();
        flush_i = 1'b0;
        refill(ABase, 0, 18'h00104);
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL flush_pending: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(ABase, 0, 18'h00104);
        n_checks++;
        if (ack_o !== 1'b1 || instr_o !== ABase)
            $display("FAIL flush_recover: ack=%b instr=%h expected 1/%h", ack_o, instr_o, ABase);
        else n_pass++;
        pc_i = 18'h00308;
        #1;
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL flush_other: ack=%b expected 0", ack_o);
        else n_pass++;
        refill(DBase, 0, 18'h00308);
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_ack_in_lookup();
        test_conflict();
        test_boundary();
        test_stalled();
        test_reset_mid_refill();
`ifdef TTA_FETCH_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
